// File: rtl/score_display.sv
// score_display: latches player/house sums and converts each to two BCD digits
// with a shared-timing double-dabble engine. It then multiplexes the four digits
// onto a single seven-segment bus. display_ready tells the controller when a new
// pair of sums can be loaded.
module score_display #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] player_sum,
  input  logic [5:0] house_sum,
  output logic       display_ready,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  // Active-high pattern for "0"; the reset image shows player ones as "0".
  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  localparam logic [6:0] SEG_RST  = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [3:0] AN_RST   = SEG_ACTIVE_LOW ? 4'b1110 : 4'b0001;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t      state;
  logic [5:0]  player_shift;
  logic [5:0]  house_shift;
  logic [7:0]  player_bcd;
  logic [7:0]  house_bcd;
  logic [2:0]  iter;
  // digit_reg index matches the an bit: 0 player ones, 1 player tens,
  // 2 house ones, 3 house tens.
  logic [3:0]  digit_reg [4];

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic          wrap;
  logic [1:0]    idx_next;
  logic [3:0]    digit_sel;
  logic          blank;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  // One double-dabble step: add 3 to any nibble >= 5, then shift in the next bit.
  function automatic logic [7:0] dabble(input logic [7:0] bcd, input logic bit_in);
    logic [7:0] adj;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return {adj[6:0], bit_in};
  endfunction

  // Active-high segment pattern {g..a} for one decimal digit, or all off when blanked.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d, input logic blank_in);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    if (blank_in) p = 7'b0000000;
    return p;
  endfunction

  // Load/convert/commit sequencer; the displayed digits only change in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      display_ready <= 1'b1;
      player_shift  <= '0;
      house_shift   <= '0;
      player_bcd    <= '0;
      house_bcd     <= '0;
      iter          <= '0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            player_shift  <= player_sum;
            house_shift   <= house_sum;
            player_bcd    <= '0;
            house_bcd     <= '0;
            iter          <= '0;
            display_ready <= 1'b0;
            state         <= CONVERT;
          end
        end
        CONVERT: begin
          player_bcd   <= dabble(player_bcd, player_shift[5]);
          house_bcd    <= dabble(house_bcd, house_shift[5]);
          player_shift <= {player_shift[4:0], 1'b0};
          house_shift  <= {house_shift[4:0], 1'b0};
          iter         <= iter + 3'd1;
          if (iter == 3'd5) state <= COMMIT;
        end
        COMMIT: begin
          digit_reg[0]  <= player_bcd[3:0];
          digit_reg[1]  <= player_bcd[7:4];
          digit_reg[2]  <= house_bcd[3:0];
          digit_reg[3]  <= house_bcd[7:4];
          display_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          display_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  // Pick the digit that will be enabled after this edge and build its pattern,
  // so seg and an always move together.
  always_comb begin
    wrap      = (refresh_cnt == CNT_LAST);
    idx_next  = wrap ? digit_idx + 2'd1 : digit_idx;
    digit_sel = digit_reg[idx_next];
    // Odd indices are tens digits: a leading zero is blanked.
    blank     = idx_next[0] && (digit_sel == 4'd0);
    seg_next  = seg_pattern(digit_sel, blank);
    an_next   = 4'b0001 << idx_next;
    if (SEG_ACTIVE_LOW) begin
      seg_next = ~seg_next;
      an_next  = ~an_next;
    end
  end

  // Free-running refresh counter, digit index and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      seg         <= SEG_RST;
      an          <= AN_RST;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      digit_idx   <= idx_next;
      seg         <= seg_next;
      an          <= an_next;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed bench for score_display with a decimal-level
// reference model checked on every cycle, plus hand-computed digit patterns.
module tb_score_display;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic       load;
  logic [5:0] player_sum;
  logic [5:0] house_sum;
  logic       display_ready;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  score_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .player_sum(player_sum),
    .house_sum(house_sum),
    .display_ready(display_ready),
    .seg(seg),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal values shown, busy countdown, and edges since reset.
  int         n_edges;
  int         shown_p, shown_h;
  int         lat_p, lat_h;
  int         busy_left;
  logic       exp_ready;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;

  // Active-high digit shapes {g..a} for 0..9.
  logic [6:0] shapes [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  task automatic model_outputs(input int pv, input int hv, input int idx);
    int   val;
    logic [6:0] p;
    case (idx)
      0: val = pv % 10;
      1: val = pv / 10;
      2: val = hv % 10;
      default: val = hv / 10;
    endcase
    p = shapes[val];
    if ((idx % 2 == 1) && val == 0) p = 7'b0000000;
    exp_seg = ~p;
    exp_an  = ~(4'b0001 << idx);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_edges   = 0;
      shown_p   = 0;
      shown_h   = 0;
      busy_left = 0;
      exp_ready = 1'b1;
      model_outputs(0, 0, 0);
    end else begin
      n_edges = n_edges + 1;
      // Output register picks up the digits as they stood before this edge.
      model_outputs(shown_p, shown_h, (n_edges / DIV) % 4);
      if (busy_left == 0) begin
        if (load) begin
          lat_p     = player_sum;
          lat_h     = house_sum;
          busy_left = 7;
        end
      end else begin
        busy_left = busy_left - 1;
        if (busy_left == 0) begin
          shown_p = lat_p;
          shown_h = lat_h;
        end
      end
      exp_ready = (busy_left == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", 32'(display_ready), 32'(exp_ready));
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg));
    end
  end

  // Issue a one-cycle load and count the cycles display_ready stays low.
  task automatic load_and_time(input logic [5:0] p, input logic [5:0] h, output int busy);
    @(negedge clk);
    load = 1'b1; player_sum = p; house_sum = h;
    @(negedge clk);
    load = 1'b0;
    busy = 0;
    while (display_ready == 1'b0 && busy < 30) begin
      busy++;
      @(negedge clk);
    end
    $display("load player=%0d house=%0d busy=%0d", p, h, busy);
  endtask

  // Wait (bounded) until the given digit is enabled, then check its pattern.
  task automatic digit_is(input string name, input logic [3:0] an_t, input logic [6:0] seg_req);
    int i;
    i = 0;
    @(negedge clk);
    while (an !== an_t && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_enable"}, 32'(an), 32'(an_t));
    chk(name, 32'(seg), 32'(seg_req));
  endtask

  task automatic wait_ready(input logic val, input string name);
    int i;
    i = 0;
    while (display_ready !== val && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(display_ready), 32'(val));
  endtask

  int busy;
  int nc = 0;
  int rise_t [4];
  logic [5:0] plist [5] = '{6'd12, 6'd34, 6'd56, 6'd7, 6'd0};
  logic [5:0] hlist [5] = '{6'd40, 6'd3, 6'd19, 6'd63, 6'd0};

  always @(negedge clk) nc++;

  initial begin
    rst = 1'b0; load = 1'b0; player_sum = '0; house_sum = '0;
    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(display_ready), 32'd1);
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    $display("reset: ready=%b an=%b seg=%b", display_ready, an, seg);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Normal load 21/17.
    load_and_time(6'd21, 6'd17, busy);
    chk("busy_21_17", 32'(busy), 32'd7);
    digit_is("p1_ones", 4'b1110, 7'b1111001);
    digit_is("p1_tens", 4'b1101, 7'b0100100);
    digit_is("h1_ones", 4'b1011, 7'b1111000);
    digit_is("h1_tens", 4'b0111, 7'b1111001);

    // Loads during conversion are ignored.
    fork
      load_and_time(6'd5, 6'd10, busy);
      begin
        @(negedge clk);
        @(negedge clk);
        repeat (2) @(negedge clk);
        load = 1'b1; player_sum = 6'd63; house_sum = 6'd63;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    join
    chk("busy_5_10", 32'(busy), 32'd7);
    repeat (3) @(negedge clk);
    chk("no_second_busy", 32'(display_ready), 32'd1);
    digit_is("p2_ones", 4'b1110, 7'b0010010);
    digit_is("p2_tens", 4'b1101, 7'b1111111);
    digit_is("h2_ones", 4'b1011, 7'b1000000);
    digit_is("h2_tens", 4'b0111, 7'b1111001);

    // Boundaries 0/63 then 9/10.
    load_and_time(6'd0, 6'd63, busy);
    chk("busy_0_63", 32'(busy), 32'd7);
    digit_is("p3_ones", 4'b1110, 7'b1000000);
    digit_is("p3_tens", 4'b1101, 7'b1111111);
    digit_is("h3_ones", 4'b1011, 7'b0110000);
    digit_is("h3_tens", 4'b0111, 7'b0000010);
    load_and_time(6'd9, 6'd10, busy);
    digit_is("p4_tens", 4'b1101, 7'b1111111);
    digit_is("h4_tens", 4'b0111, 7'b1111001);

    // Reset during CONVERT.
    @(negedge clk);
    load = 1'b1; player_sum = 6'd21; house_sum = 6'd21;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(display_ready), 32'd1);
    chk("midrst_an", 32'(an), 32'(4'b1110));
    chk("midrst_seg", 32'(seg), 32'(7'b1000000));
    $display("mid-conversion reset: ready=%b an=%b seg=%b", display_ready, an, seg);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_rst_seg", 32'(seg), 32'(7'b1000000));
    load_and_time(6'd21, 6'd21, busy);
    chk("busy_after_rst", 32'(busy), 32'd7);
    digit_is("p5_tens", 4'b1101, 7'b0100100);

    // Held load with sums changing once per period.
    @(negedge clk);
    load = 1'b1; player_sum = plist[0]; house_sum = hlist[0];
    for (int k = 0; k < 4; k++) begin
      wait_ready(1'b0, "held_start");
      player_sum = plist[k + 1]; house_sum = hlist[k + 1];
      wait_ready(1'b1, "held_commit");
      rise_t[k] = nc;
      $display("held commit %0d at negedge %0d", k, nc);
    end
    load = 1'b0;
    for (int k = 1; k < 4; k++) chk("held_spacing", 32'(rise_t[k] - rise_t[k - 1]), 32'd8);
    repeat (4) @(negedge clk);
    chk("held_idle", 32'(display_ready), 32'd1);
    digit_is("p6_ones", 4'b1110, 7'b1111000);
    digit_is("h6_tens", 4'b0111, 7'b0000010);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
